mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master, one-slave memory arbiter that lets the CtlUnit instruction-fetch port (m0) and load/store port (m1) share a single memory/peripheral port (RAM plus the GPIO register window).
- Round-robin arbitration on simultaneous requests, one outstanding transaction at a time.
- Includes a bus-timeout watchdog so a dead slave cannot hang the core.
- Sits between the CtlUnit datapath and the memory/GPIO decode logic.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of read/write data buses; byte enables are DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, BUSY cycles allowed without mem_ack before an error completion; 0 disables the watchdog.

Ports:
- sys_clk  in  1  clock; everything is on the rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- m0_req  in  1  fetch request; held high until m0_ack.
- m0_addr  in  ADDR_WIDTH  fetch address; read-only master, no write signals.
- m0_ack  out  1  one-cycle completion pulse to m0.
- m0_err  out  1  valid with m0_ack; 1 = timeout.
- m0_rdata  out  DATA_WIDTH  read data, valid with m0_ack.
- m1_req  in  1  load/store request; held until m1_ack.
- m1_we  in  1  1 = write.
- m1_addr  in  ADDR_WIDTH  data address.
- m1_wdata  in  DATA_WIDTH  write data.
- m1_be  in  DATA_WIDTH/8  byte enables.
- m1_ack  out  1  completion pulse to m1.
- m1_err  out  1  valid with m1_ack; 1 = timeout.
- m1_rdata  out  DATA_WIDTH  read data, valid with m1_ack.
- mem_req  out  1  slave request; registered.
- mem_we  out  1  registered write enable.
- mem_addr  out  ADDR_WIDTH  registered address.
- mem_wdata  out  DATA_WIDTH  registered write data.
- mem_be  out  DATA_WIDTH/8  registered byte enables.
- mem_ack  in  1  slave completion; may be asserted in the first mem_req cycle.
- mem_rdata  in  DATA_WIDTH  slave read data, valid with mem_ack.
- arb_owner  out  1  granted master: 0 = m0, 1 = m1; valid while arb_busy.
- arb_busy  out  1  transaction outstanding.

Behaviour:
- Reset values:
  - mem_req, mem_we, arb_busy, arb_owner = 0.
  - mem_addr, mem_wdata = 0; mem_be = 0.
  - All m*_ack and m*_err = 0; m*_rdata = 0.
  - FSM state = IDLE; last_grant = 1; timeout counter = 0.
- FSM:
  - IDLE: if any req is high, select the winner, latch its command into the mem_* registers, set mem_req, arb_busy and arb_owner, and go to BUSY on the next edge.
  - BUSY: hold every mem_* output stable.
    - On mem_ack: pulse the owner's ack combinationally in the same cycle, drive owner rdata = mem_rdata, err = 0. On the next edge, clear mem_req and arb_busy, set last_grant = owner, return to IDLE.
    - On timeout (counter reaches TIMEOUT_CYCLES with no mem_ack): same completion, but err = 1 and rdata = 0.
- Arbitration:
  - Only one request high: that master wins.
  - Both high: grant the master that is not last_grant. After reset, m0 wins first.
- Commands:
  - m0 grant drives mem_we = 0 and mem_be = all ones.
  - A non-owner's ack, err and rdata stay 0.
- Latency:
  - req high at IDLE cycle t -> mem_req high at t+1.
  - Fastest completion: ack at t+1.
  - Back-to-back: next mem_req at t+3 at the earliest (t+2 is the IDLE arbitration cycle).
- Request-line rule: a master's req in the cycle after its ack counts as a new request. Masters must drop req or present the next command in that cycle.
- Timeout counter:
  - Clears on entry to BUSY and increments each BUSY cycle without mem_ack.
  - mem_ack wins if it arrives in the same cycle as the timeout.
- Requests arriving while BUSY are held pending and arbitrated at the next IDLE cycle. No request is dropped.
- Reset asserted mid-transaction:
  - The transaction is abandoned; no ack is issued.
  - All outputs return to reset values on that edge.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: m1 (load/store) always wins simultaneous requests, and last_grant is unused. This gives deterministic data-access timing for GPIO polling.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then m0_req with m0_addr = 0x00000010; slave acks in the first cycle with 0x00A00093 -> mem_req at t+1, mem_addr = 0x10, mem_we = 0, m0_ack and m0_rdata = 0x00A00093 at t+1, m1_ack stays 0.
- m1 write: addr = 0x80000000, wdata = 0x12345678, be = 0xF; slave acks after 3 cycles -> mem_* outputs stable all 3 cycles, m1_ack single pulse, m1_err = 0.
- m0 and m1 both held high for 4 transactions -> grant order m0, m1, m0, m1. With MEM_ARB_FIXED_PRIO_EN, m1 is granted while m1_req stays high.
- TIMEOUT_CYCLES = 4, slave never acks -> m1_ack with m1_err = 1 and m1_rdata = 0 after 4 BUSY cycles; FSM returns to IDLE.
- sys_rst pulsed on the second BUSY cycle -> next edge mem_req = 0, arb_busy = 0, no ack pulse; a fresh m0 request then proceeds normally.
- m1_req raised during an m0 transaction -> m1 granted in the IDLE cycle right after m0_ack, mem_req again 2 cycles after m0_ack.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles both master ports, the shared slave port and the
// arbiter status lines. The slave modport is the arbiter's view; the master
// modport is the view of the surrounding CtlUnit / memory environment.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  // Instruction-fetch master (read-only)
  logic                  m0_req;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic                  m0_ack;
  logic                  m0_err;
  logic [DATA_WIDTH-1:0] m0_rdata;

  // Load/store master
  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic [BE_WIDTH-1:0]   m1_be;
  logic                  m1_ack;
  logic                  m1_err;
  logic [DATA_WIDTH-1:0] m1_rdata;

  // Shared memory / GPIO slave port
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BE_WIDTH-1:0]   mem_be;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter status
  logic                  arb_owner;
  logic                  arb_busy;

  modport slave (
    input  m0_req, m0_addr,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    output m1_ack, m1_err, m1_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata,
    output arb_owner, arb_busy
  );

  modport master (
    output m0_req, m0_addr,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    input  m1_ack, m1_err, m1_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata,
    input  arb_owner, arb_busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory/GPIO slave port between the CtlUnit fetch
// port (m0) and load/store port (m1). One transaction outstanding at a time,
// round-robin on ties, with a bus-timeout watchdog that completes a hung
// transaction with an error.
// Build option MEM_ARB_FIXED_PRIO_EN: m1 always wins simultaneous requests.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e                state_q;
  state_e                state_d;

  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [BE_WIDTH-1:0]   mem_be_q;
  logic                  arb_busy_q;
  logic                  arb_owner_q;
  logic [CNT_WIDTH-1:0]  tmo_cnt_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic                  last_grant_q;
`endif

  logic                  any_req_c;
  logic                  grant_c;
  logic                  start_c;
  logic                  timeout_c;
  logic                  done_c;
  logic                  m0_ack_c;
  logic                  m0_err_c;
  logic [DATA_WIDTH-1:0] m0_rdata_c;
  logic                  m1_ack_c;
  logic                  m1_err_c;
  logic [DATA_WIDTH-1:0] m1_rdata_c;

  assign any_req_c = bus.m0_req | bus.m1_req;
  assign start_c   = (state_q == ST_IDLE) & any_req_c;

  // Winner of the current IDLE cycle: 1 selects m1
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign grant_c = bus.m1_req;
`else
  assign grant_c = (bus.m0_req & bus.m1_req) ? ~last_grant_q : bus.m1_req;
`endif

  // Watchdog expiry; a same-cycle mem_ack takes precedence
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_wdog
      assign timeout_c = 1'b0;
    end else begin : g_wdog
      assign timeout_c = (state_q == ST_BUSY) & ~bus.mem_ack &
                         (tmo_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES));
    end
  endgenerate

  // A reset in the completion cycle abandons the transaction without an ack
  assign done_c = (state_q == ST_BUSY) & (bus.mem_ack | timeout_c) & ~sys_rst;

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req_c) state_d = ST_BUSY;
      ST_BUSY: if (done_c)    state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Completion pulse, error and read data to the owning master only
  always_comb begin
    m0_ack_c   = 1'b0;
    m0_err_c   = 1'b0;
    m0_rdata_c = '0;
    m1_ack_c   = 1'b0;
    m1_err_c   = 1'b0;
    m1_rdata_c = '0;
    if (done_c) begin
      if (arb_owner_q) begin
        m1_ack_c   = 1'b1;
        m1_err_c   = ~bus.mem_ack;
        m1_rdata_c = bus.mem_ack ? bus.mem_rdata : '0;
      end else begin
        m0_ack_c   = 1'b1;
        m0_err_c   = ~bus.mem_ack;
        m0_rdata_c = bus.mem_ack ? bus.mem_rdata : '0;
      end
    end
  end

  // Command latch, ownership and watchdog counter
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      arb_busy_q  <= 1'b0;
      arb_owner_q <= 1'b0;
      tmo_cnt_q   <= '0;
    end else if (start_c) begin
      mem_req_q   <= 1'b1;
      arb_busy_q  <= 1'b1;
      arb_owner_q <= grant_c;
      tmo_cnt_q   <= '0;
      if (grant_c) begin
        mem_we_q    <= bus.m1_we;
        mem_addr_q  <= bus.m1_addr;
        mem_wdata_q <= bus.m1_wdata;
        mem_be_q    <= bus.m1_be;
      end else begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= bus.m0_addr;
        mem_wdata_q <= '0;
        mem_be_q    <= '1;
      end
    end else if (done_c) begin
      mem_req_q  <= 1'b0;
      arb_busy_q <= 1'b0;
    end else if (state_q == ST_BUSY) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_WIDTH'(1);
    end
  end

`ifndef MEM_ARB_FIXED_PRIO_EN
  // Round-robin history: owner of the most recently completed transaction
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      last_grant_q <= 1'b1;
    end else if (done_c) begin
      last_grant_q <= arb_owner_q;
    end
  end
`endif

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.arb_busy  = arb_busy_q;
  assign bus.arb_owner = arb_owner_q;
  assign bus.m0_ack    = m0_ack_c;
  assign bus.m0_err    = m0_err_c;
  assign bus.m0_rdata  = m0_rdata_c;
  assign bus.m1_ack    = m1_ack_c;
  assign bus.m1_err    = m1_err_c;
  assign bus.m1_rdata  = m1_rdata_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a 4-cycle watchdog.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus    (bus)
  );

  typedef struct {
    logic        owner;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          m0_todo;
  int          m1_todo;
  int          slv_lat;   // cycles of mem_req before mem_ack; negative = never
  int          slv_cnt;
  logic [31:0] rd_key;    // slave read data = mem_addr ^ rd_key

  // One clock: slave response at negedge, then scoreboard and master models
  task automatic tick();
    exp_t        e;
    logic        own;
    logic        er;
    logic [31:0] rd;
    @(negedge clk);
    if (bus.mem_req === 1'b1) begin
      bus.mem_rdata = bus.mem_addr ^ rd_key;
      bus.mem_ack   = (slv_lat >= 0) && (slv_cnt == slv_lat);
      slv_cnt++;
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      slv_cnt       = 0;
    end
    #1;
    if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) begin
      own = bus.m1_ack;
      checks++;
      if (bus.m0_ack === 1'b1 && bus.m1_ack === 1'b1) begin
        errors++;
        $display("FAIL both_acks: m0_ack=1 m1_ack=1, required one at a time");
      end else if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: owner=%0d, required no ack", own);
      end else begin
        e  = sb_q.pop_front();
        rd = own ? bus.m1_rdata : bus.m0_rdata;
        er = own ? bus.m1_err : bus.m0_err;
        if (own !== e.owner || er !== e.err || rd !== e.rdata) begin
          errors++;
          $display("FAIL completion: owner=%0d err=%0d rdata=%h, required owner=%0d err=%0d rdata=%h",
                   own, er, rd, e.owner, e.err, e.rdata);
        end
      end
      if (bus.m0_ack === 1'b1) begin
        m0_todo--;
        if (m0_todo <= 0) bus.m0_req = 1'b0;
      end
      if (bus.m1_ack === 1'b1) begin
        m1_todo--;
        if (m1_todo <= 0) bus.m1_req = 1'b0;
      end
    end
    checks++;
    if ((bus.m0_ack !== 1'b1 && (bus.m0_err !== 1'b0 || bus.m0_rdata !== 32'h0)) ||
        (bus.m1_ack !== 1'b1 && (bus.m1_err !== 1'b0 || bus.m1_rdata !== 32'h0))) begin
      errors++;
      $display("FAIL quiet_master: m0 err=%b rdata=%h m1 err=%b rdata=%h, required 0 without ack",
               bus.m0_err, bus.m0_rdata, bus.m1_err, bus.m1_rdata);
    end
  endtask

  task automatic wait_drain(input int budget, output int n);
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.arb_busy, bus.arb_owner, bus.mem_addr, bus.mem_wdata,
         bus.mem_be, bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err, bus.m0_rdata,
         bus.m1_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_state: mem_req=%b busy=%b owner=%b addr=%h be=%h acks=%b%b, required all 0",
               bus.mem_req, bus.arb_busy, bus.arb_owner, bus.mem_addr, bus.mem_be,
               bus.m0_ack, bus.m1_ack);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    slv_lat = 0;
    rd_key  = 32'h00A00093 ^ 32'h00000010;
    tick();
    bus.m0_addr = 32'h0000_0010;
    bus.m0_req  = 1'b1;
    m0_todo     = 1;
    sb_q.push_back('{1'b0, 1'b0, 32'h00A00093});
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_req_cycle: mem_req=%b, required 0", bus.mem_req);
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_we !== 1'b0 ||
        bus.mem_be !== 4'hF || bus.arb_owner !== 1'b0) begin
      errors++;
      $display("FAIL fetch_cmd: req=%b addr=%h we=%b be=%h owner=%b, required 1 00000010 0 f 0",
               bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_be, bus.arb_owner);
    end
    checks++;
    if (bus.m0_ack !== 1'b1 || bus.m0_rdata !== 32'h00A00093) begin
      errors++;
      $display("FAIL fetch_ack: m0_ack=%b rdata=%h, required 1 00a00093", bus.m0_ack, bus.m0_rdata);
    end
    checks++;
    if (bus.m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL fetch_m1_quiet: m1_ack=%b, required 0", bus.m1_ack);
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b0 || bus.arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_idle: mem_req=%b busy=%b, required 0 0", bus.mem_req, bus.arb_busy);
    end
  endtask

  task automatic test_write();
    int ack_cnt = 0;
    int err_cnt = 0;
    int ack_at  = 0;
    slv_lat = 3;
    rd_key  = 32'h1111_0000;
    tick();
    bus.m1_we    = 1'b1;
    bus.m1_addr  = 32'h8000_0000;
    bus.m1_wdata = 32'h1234_5678;
    bus.m1_be    = 4'hF;
    bus.m1_req   = 1'b1;
    m1_todo      = 1;
    sb_q.push_back('{1'b1, 1'b0, 32'h9111_0000});
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h8000_0000 ||
          bus.mem_wdata !== 32'h1234_5678 || bus.mem_be !== 4'hF || bus.arb_owner !== 1'b1 ||
          bus.arb_busy !== 1'b1) begin
        errors++;
        $display("FAIL write_hold_%0d: req=%b we=%b addr=%h wdata=%h be=%h owner=%b, required 1 1 80000000 12345678 f 1",
                 i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.arb_owner);
      end
      if (bus.m1_ack === 1'b1) begin
        ack_cnt++;
        ack_at = i;
      end
      if (bus.m1_err === 1'b1) err_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.m1_ack === 1'b1) ack_cnt++;
      if (bus.m1_err === 1'b1) err_cnt++;
    end
    checks++;
    if (ack_cnt != 1 || ack_at != 4 || err_cnt != 0) begin
      errors++;
      $display("FAIL write_ack_pulse: acks=%0d at_cycle=%0d errs=%0d, required 1 4 0",
               ack_cnt, ack_at, err_cnt);
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic        own;
    logic [31:0] rd;
    slv_lat = 1;
    rd_key  = 32'h5A5A_0000;
    tick();
    bus.m0_addr  = 32'h0000_0100;
    bus.m1_we    = 1'b0;
    bus.m1_addr  = 32'h0000_0200;
    bus.m1_wdata = '0;
    bus.m1_be    = 4'h3;
    bus.m0_req   = 1'b1;
    bus.m1_req   = 1'b1;
    m0_todo      = 3;
    m1_todo      = 3;
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      own = (k < 3);
`else
      own = (k % 2) == 1;
`endif
      rd = own ? 32'h5A5A_0200 : 32'h5A5A_0100;
      sb_q.push_back('{own, 1'b0, rd});
    end
    wait_drain(60, n);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: %0d completions outstanding, required 0", sb_q.size());
    end
    checks++;
    if (n != 17) begin
      errors++;
      $display("FAIL rr_back_to_back: last ack after %0d cycles, required 17", n);
    end
  endtask

  task automatic test_timeout();
    int ack_at = 0;
    slv_lat = -1;
    rd_key  = 32'h7777_0000;
    tick();
    bus.m1_we   = 1'b0;
    bus.m1_addr = 32'h0000_0300;
    bus.m1_be   = 4'hF;
    bus.m1_req  = 1'b1;
    m1_todo     = 1;
    sb_q.push_back('{1'b1, 1'b1, 32'h0});
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.m1_ack === 1'b1 && ack_at == 0) ack_at = i;
    end
    checks++;
    if (ack_at != 5) begin
      errors++;
      $display("FAIL timeout_cycle: error ack at cycle %0d, required 5", ack_at);
    end
    checks++;
    if (bus.arb_busy !== 1'b0 || bus.mem_req !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_idle: busy=%b mem_req=%b pending=%0d, required 0 0 0",
               bus.arb_busy, bus.mem_req, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    slv_lat = -1;
    rd_key  = 32'h0F0F_0000;
    tick();
    bus.m0_addr = 32'h0000_0040;
    bus.m0_req  = 1'b1;
    m0_todo     = 1;
    tick();
    checks++;
    if (bus.arb_busy !== 1'b1 || bus.arb_owner !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_busy: busy=%b owner=%b, required 1 0", bus.arb_busy, bus.arb_owner);
    end
    tick();
    rst        = 1'b1;
    bus.m0_req = 1'b0;
    m0_todo    = 0;
    #1;
    checks++;
    if (bus.m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_ack: m0_ack=%b, required 0", bus.m0_ack);
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b0 || bus.arb_busy !== 1'b0 || bus.arb_owner !== 1'b0 ||
        bus.m0_ack !== 1'b0 || bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_cleared: req=%b busy=%b owner=%b ack=%b addr=%h, required all 0",
               bus.mem_req, bus.arb_busy, bus.arb_owner, bus.m0_ack, bus.mem_addr);
    end
    rst     = 1'b0;
    slv_lat = 0;
    tick();
    bus.m0_addr = 32'h0000_0044;
    bus.m0_req  = 1'b1;
    m0_todo     = 1;
    sb_q.push_back('{1'b0, 1'b0, 32'h0F0F_0044});
    wait_drain(10, n);
    checks++;
    if (sb_q.size() != 0 || n != 1) begin
      errors++;
      $display("FAIL rstmid_fresh: pending=%0d cycles=%0d, required 0 1", sb_q.size(), n);
    end
  endtask

  task automatic test_pending();
    int   n;
    logic found = 1'b0;
    slv_lat = 2;
    rd_key  = 32'h3C3C_0000;
    tick();
    bus.m0_addr = 32'h0000_0080;
    bus.m0_req  = 1'b1;
    m0_todo     = 1;
    sb_q.push_back('{1'b0, 1'b0, 32'h3C3C_0080});
    tick();
    tick();
    bus.m1_we    = 1'b1;
    bus.m1_addr  = 32'h0000_0090;
    bus.m1_wdata = 32'hCAFE_F00D;
    bus.m1_be    = 4'h5;
    bus.m1_req   = 1'b1;
    m1_todo      = 1;
    sb_q.push_back('{1'b1, 1'b0, 32'h3C3C_0090});
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.m0_ack === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL pend_m0_ack: no m0_ack within 10 cycles, required one");
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b0 || bus.arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL pend_idle: mem_req=%b busy=%b, required 0 0", bus.mem_req, bus.arb_busy);
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.arb_owner !== 1'b1 || bus.mem_we !== 1'b1 ||
        bus.mem_addr !== 32'h90 || bus.mem_wdata !== 32'hCAFE_F00D || bus.mem_be !== 4'h5) begin
      errors++;
      $display("FAIL pend_m1_grant: req=%b owner=%b we=%b addr=%h wdata=%h be=%h, required 1 1 1 00000090 cafef00d 5",
               bus.mem_req, bus.arb_owner, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
    end
    wait_drain(10, n);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pend_drain: %0d completions outstanding, required 0", sb_q.size());
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.m0_req    = 1'b0;
    bus.m0_addr   = '0;
    bus.m1_req    = 1'b0;
    bus.m1_we     = 1'b0;
    bus.m1_addr   = '0;
    bus.m1_wdata  = '0;
    bus.m1_be     = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    m0_todo       = 0;
    m1_todo       = 0;
    slv_lat       = 0;
    slv_cnt       = 0;
    rd_key        = '0;
    test_reset();
    test_fetch();
    test_write();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
